xil_mem_sp_arb: RTL
===================

# xil_mem_sp_arb

Two-requester arbiter and sequencer for a 512x32 single-port byte-writable block RAM with registered, read-first output. It shares the one memory port between two clients (A, B) using round-robin priority, and returns read data one cycle after grant. It also owns a clear sequencer that fills the whole array with a constant after reset or on command. It sits between the memory macro and its client logic, and is the only driver of the memory's enable, byte-write-enable, address and write-data inputs.

## Interface
- CLEAR_ON_RESET, 1: when 1, a full clear runs automatically after reset release.
- INIT_VALUE, 32'h0000_0000: word written to every address during a clear.

- clk  in  1  clock; memory shares this clock
- rst_n  in  1  asynchronous, active-low reset
- i_a_req  in  1  client A access request; held with its qualifiers until granted
- i_a_wen  in  4  client A byte write enables; 0 means read
- i_a_adr  in  9  client A word address
- i_a_wdata  in  32  client A write data
- o_a_gnt  out  1  access issued to memory this cycle (combinational)
- o_a_rvalid  out  1  o_a_rdata valid (registered)
- o_a_rdata  out  32  read data, equal to i_mem_rdata
- i_b_*, o_b_*: same as A, for client B
- i_clear  in  1  single-cycle pulse requesting a clear
- o_busy  out  1  clear in progress; no grants
- o_mem_en  out  1  memory enable
- o_mem_wen  out  4  memory byte write enables
- o_mem_adr  out  9  memory address
- o_mem_wdata  out  32  memory write data
- i_mem_rdata  in  32  memory registered read data (old word, read-first)

## Operation
- States: CLEAR, SERVE. Reset state is CLEAR if CLEAR_ON_RESET=1, else SERVE.
- CLEAR:
  - 9-bit counter starts at 0; each cycle drives o_mem_en=1, o_mem_wen=4'hF, o_mem_adr=counter, o_mem_wdata=INIT_VALUE.
  - At counter 511, go to SERVE; the counter wraps to 0.
  - o_busy=1 throughout; gnt and rvalid stay 0; i_clear is ignored; requests wait.
- SERVE:
  - One request pending: it is granted the same cycle.
  - Both pending: grant the client not granted last. The last-granted pointer resets to B, so A wins the first contention.
  - The pointer updates only on a grant.
  - Granted client's wen/adr/wdata pass to memory, with o_mem_en=1.
  - No request: o_mem_en=0, and o_mem_wen/adr/wdata are don't-care (driven 0).
- Byte writes follow wen: 4'b0001 writes byte 0 only, and the other bytes keep their contents.
- Read response: rvalid_x is 1 in cycle N+1 if x was granted in cycle N with wen==0. Writes produce no rvalid.
- i_clear in SERVE: requests are still arbitrated normally in that cycle; CLEAR is entered next cycle.
- While rst_n=0: state/counter/pointer are held at reset values, and all gnt, rvalid and o_mem_en are 0.
- Reset outputs: o_a/b_gnt=0, o_a/b_rvalid=0, o_mem_en=0, o_mem_wen=0, o_mem_adr=0, o_mem_wdata=0, o_busy=CLEAR_ON_RESET.

## Timing
- Grant latency: 0 cycles from req when uncontended in SERVE. At most 1 extra cycle under contention, since round-robin gives each client a slot every other cycle.
- Read latency: rvalid/rdata exactly 1 cycle after grant.
- Back-to-back grants to the same client are allowed every cycle; rvalid stays high continuously for consecutive reads.
- Clear length: exactly 512 cycles of o_busy=1.
  - Reset-triggered: first clear write occurs on the first rising edge after rst_n deasserts.
  - i_clear-triggered: busy rises the cycle after the pulse.
- Reset asserted mid-clear aborts it. With CLEAR_ON_RESET=1 the clear restarts from address 0 after release.
- Reset asserted between grant and rvalid suppresses that rvalid.

## Test plan
- Reset with CLEAR_ON_RESET=1, INIT_VALUE=32'hDEAD_BEEF: o_busy high for 512 cycles, writes to adr 0..511 in order. A then reads adr 0x1FF: gnt immediate, rvalid next cycle, rdata 32'hDEAD_BEEF.
- A writes adr 5 = 32'h1122_3344 with wen=4'hF, then with wen=4'b0100 writes 32'h00AA_0000. A read of adr 5 returns 32'h11AA_3344, and no rvalid follows either write.
- A and B both hold read requests for 4 cycles: grants go A, B, A, B; each rvalid arrives the following cycle on the matching client only.
- i_clear pulsed while B is requesting: B granted that cycle, then busy for 512 cycles with B held off. After clear, B granted and B read returns INIT_VALUE.
- rst_n pulsed low at clear counter 200: all outputs take their reset values immediately; after release the clear restarts at address 0 and lasts 512 cycles.
- CLEAR_ON_RESET=0: o_busy=0 out of reset, and an A request in the first cycle after release is granted immediately.

Source files
------------

// File: rtl/xil_mem_sp_arb.sv
// Round-robin arbiter for two clients sharing one single-port byte-writable
// 512x32 block RAM, plus a sequencer that fills the array with INIT_VALUE.
module xil_mem_sp_arb #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] INIT_VALUE     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_a_req,
  input  logic [3:0]  i_a_wen,
  input  logic [8:0]  i_a_adr,
  input  logic [31:0] i_a_wdata,
  output logic        o_a_gnt,
  output logic        o_a_rvalid,
  output logic [31:0] o_a_rdata,
  input  logic        i_b_req,
  input  logic [3:0]  i_b_wen,
  input  logic [8:0]  i_b_adr,
  input  logic [31:0] i_b_wdata,
  output logic        o_b_gnt,
  output logic        o_b_rvalid,
  output logic [31:0] o_b_rdata,
  input  logic        i_clear,
  output logic        o_busy,
  output logic        o_mem_en,
  output logic [3:0]  o_mem_wen,
  output logic [8:0]  o_mem_adr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam logic [AW-1:0] LAST_ADR = {AW{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_b_q, last_b_d;   // 1: B was granted most recently
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;

  logic          a_gnt_c;
  logic          b_gnt_c;
  logic          mem_en_c;
  logic [BW-1:0] mem_wen_c;
  logic [AW-1:0] mem_adr_c;
  logic [DW-1:0] mem_wdata_c;

  // State, clear counter, round-robin pointer and read-valid flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Next state, arbitration and memory port mux
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_b_d    = last_b_q;
    a_gnt_c     = 1'b0;
    b_gnt_c     = 1'b0;
    mem_en_c    = 1'b0;
    mem_wen_c   = '0;
    mem_adr_c   = '0;
    mem_wdata_c = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_en_c    = 1'b1;
        mem_wen_c   = {BW{1'b1}};
        mem_adr_c   = cnt_q;
        mem_wdata_c = INIT_VALUE;
        cnt_d       = cnt_q + AW'(1);
        if (cnt_q == LAST_ADR) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // A wins unless B is requesting and A was served last
        a_gnt_c = i_a_req & (~i_b_req | last_b_q);
        b_gnt_c = i_b_req & ~a_gnt_c;
        if (a_gnt_c) begin
          mem_en_c    = 1'b1;
          mem_wen_c   = i_a_wen;
          mem_adr_c   = i_a_adr;
          mem_wdata_c = i_a_wdata;
          last_b_d    = 1'b0;
        end else if (b_gnt_c) begin
          mem_en_c    = 1'b1;
          mem_wen_c   = i_b_wen;
          mem_adr_c   = i_b_adr;
          mem_wdata_c = i_b_wdata;
          last_b_d    = 1'b1;
        end
        if (i_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase

    a_rvalid_d = a_gnt_c & (i_a_wen == '0);
    b_rvalid_d = b_gnt_c & (i_b_wen == '0);
  end

  // Memory-facing and grant outputs are forced idle while reset is held
  assign o_a_gnt     = a_gnt_c & rst_n;
  assign o_b_gnt     = b_gnt_c & rst_n;
  assign o_mem_en    = mem_en_c & rst_n;
  assign o_mem_wen   = rst_n ? mem_wen_c : '0;
  assign o_mem_adr   = rst_n ? mem_adr_c : '0;
  assign o_mem_wdata = rst_n ? mem_wdata_c : '0;

  assign o_a_rvalid  = a_rvalid_q;
  assign o_b_rvalid  = b_rvalid_q;
  assign o_a_rdata   = i_mem_rdata;
  assign o_b_rdata   = i_mem_rdata;
  assign o_busy      = (state_q == ST_CLEAR);

endmodule
